sprite_fetcher: RTL and testbench

//  Per-scanline OAM scan and sprite tile fetch. On line_start, walks the 40 OAM entries.
//  For each sprite that covers line ly (up to MAX_SPRITES), it fetches the 2 tile bytes from VRAM.

---
 rtl/sprite_fetcher.sv | 201 ++++++++++++++++++++
 tb/tb_sprite_fetcher.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_fetcher.sv
// sprite_fetcher: per-scanline OAM scan and sprite tile fetch.
//
// On line_start the block walks OAM entries 0..OAM_ENTRIES-1 in order. Each
// entry covering line ly (up to MAX_SPRITES per line) has its two tile-row
// bytes fetched from VRAM. The sprite is then presented for one cycle on
// sprite_latch with x / priority / data_h / data_l.
//
// Optional feature macro: SPRITE_FLIP_EN. When it is defined, attr[6]
// flips the tile row vertically and attr[5] bit-reverses both planes.
// When it is undefined, attr[6:5] are ignored.
//
// Ports:
//   clock, reset        clock; synchronous active-high reset
//   line_start          1-cycle pulse; samples ly / sprite_tall and restarts the scan
//   oam_addr/oam_rdata  OAM byte read port, data one cycle after address
//   vram_req/addr/gnt   VRAM tile read; request held until granted
//   vram_rdata          VRAM data, valid the cycle after the grant
//   sprite_latch        1-cycle strobe; sprite_o_* valid
//   sprite_o_*          X, priority (attr[7]), high/low bitplanes
//   busy, done          scan in progress / 1-cycle end-of-line pulse
//   sprite_count        sprites emitted on the current line
module sprite_fetcher #(
  parameter int MAX_SPRITES = 10,
  parameter int OAM_ENTRIES = 40
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        line_start,
  input  logic [7:0]  ly,
  input  logic        sprite_tall,
  output logic [7:0]  oam_addr,
  input  logic [7:0]  oam_rdata,
  output logic        vram_req,
  output logic [11:0] vram_addr,
  input  logic        vram_gnt,
  input  logic [7:0]  vram_rdata,
  output logic        sprite_latch,
  output logic [7:0]  sprite_o_x,
  output logic        sprite_o_priority,
  output logic [7:0]  sprite_o_data_h,
  output logic [7:0]  sprite_o_data_l,
  output logic        busy,
  output logic        done,
  output logic [3:0]  sprite_count
);

  localparam logic [3:0] S_IDLE = 4'd0,  S_SY  = 4'd1,  S_SX   = 4'd2,  S_ST  = 4'd3,
                         S_SA   = 4'd4,  S_SCAP = 4'd5, S_VL   = 4'd6,  S_VLW = 4'd7,
                         S_VH   = 4'd8,  S_VHW = 4'd9,  S_EMIT = 4'd10, S_FIN = 4'd11;
  localparam logic [3:0] MAX_C  = 4'(MAX_SPRITES);
  localparam logic [5:0] LAST_C = 6'(OAM_ENTRIES - 1);

  logic [3:0] state_q, state_d;
  logic [5:0] idx_q;
  logic [7:0] ly_q;
  logic       tall_q;
  logic [3:0] row_q;
  logic [7:0] x_q, tile_q, data_l_q;
  logic       pri_q;
  logic [7:0] out_x_q, out_h_q, out_l_q;
  logic       out_pri_q;
  logic [3:0] cnt_q;

  logic [7:0]  row8;
  logic        hit, last_entry;
  logic [3:0]  cnt_inc, row_fix;
  logic [7:0]  plane_l, plane_h;
  logic [1:0]  oam_off;
  logic [10:0] tile_row;

  // Unsigned 8-bit wrap: rows above the sprite top wrap to large values and miss.
  assign row8       = ly_q + 8'd16 - oam_rdata;
  assign hit        = tall_q ? (row8 < 8'd16) : (row8 < 8'd8);
  assign last_entry = (idx_q == LAST_C);
  assign cnt_inc    = cnt_q + 4'd1;

`ifdef SPRITE_FLIP_EN
  logic xflip_q;

  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int k = 0; k < 8; k++) r[k] = v[7-k];
    return r;
  endfunction

  // Applied in SCAP, where oam_rdata carries the attribute byte.
  assign row_fix = !oam_rdata[6] ? row_q : (tall_q ? 4'd15 - row_q : 4'd7 - row_q);
  assign plane_l = xflip_q ? rev8(data_l_q)   : data_l_q;
  assign plane_h = xflip_q ? rev8(vram_rdata) : vram_rdata;

  always_ff @(posedge clock) begin
    if (reset)                  xflip_q <= 1'b0;
    else if (state_q == S_SCAP) xflip_q <= oam_rdata[5];
  end
`else
  assign row_fix = row_q;
  assign plane_l = data_l_q;
  assign plane_h = vram_rdata;
`endif

  // 8x16 sprites address an even/odd tile pair, so tile[0] is replaced by row[3].
  assign tile_row = tall_q ? {tile_q[7:1], row_q} : {tile_q, row_q[2:0]};

  always_comb begin
    oam_off = 2'd0;
    case (state_q)
      S_SX:    oam_off = 2'd1;
      S_ST:    oam_off = 2'd2;
      S_SA:    oam_off = 2'd3;
      default: oam_off = 2'd0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_SY:   state_d = S_SX;
      S_SX:   state_d = hit ? S_ST : (last_entry ? S_FIN : S_SY);
      S_ST:   state_d = S_SA;
      S_SA:   state_d = S_SCAP;
      S_SCAP: state_d = S_VL;
      S_VL:   if (vram_gnt) state_d = S_VLW;
      S_VLW:  state_d = S_VH;
      S_VH:   if (vram_gnt) state_d = S_VHW;
      S_VHW:  state_d = S_EMIT;
      S_EMIT: state_d = (cnt_inc == MAX_C || last_entry) ? S_FIN : S_SY;
      S_FIN:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // A new line pre-empts whatever is in flight.
    if (line_start) state_d = S_SY;
  end

  always_ff @(posedge clock) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      idx_q     <= '0;
      ly_q      <= '0;
      tall_q    <= 1'b0;
      row_q     <= '0;
      x_q       <= '0;
      tile_q    <= '0;
      pri_q     <= 1'b0;
      data_l_q  <= '0;
      out_x_q   <= '0;
      out_pri_q <= 1'b0;
      out_h_q   <= '0;
      out_l_q   <= '0;
      cnt_q     <= '0;
    end else if (line_start) begin
      idx_q  <= '0;
      cnt_q  <= '0;
      ly_q   <= ly;
      tall_q <= sprite_tall;
    end else begin
      case (state_q)
        S_SX: begin
          row_q <= row8[3:0];
          if (!hit && !last_entry) idx_q <= idx_q + 6'd1;
        end
        S_ST:   x_q    <= oam_rdata;
        S_SA:   tile_q <= oam_rdata;
        S_SCAP: begin
          pri_q <= oam_rdata[7];
          row_q <= row_fix;
        end
        S_VLW:  data_l_q <= vram_rdata;
        // Output registers load here so they are valid during the EMIT strobe.
        S_VHW: begin
          out_x_q   <= x_q;
          out_pri_q <= pri_q;
          out_h_q   <= plane_h;
          out_l_q   <= plane_l;
        end
        S_EMIT: begin
          cnt_q <= cnt_inc;
          if (!(cnt_inc == MAX_C || last_entry)) idx_q <= idx_q + 6'd1;
        end
        default: ;
      endcase
    end
  end

  assign oam_addr          = {idx_q, oam_off};
  // Gated so that a reset or a restart withdraws the request in the same cycle.
  assign vram_req          = (state_q == S_VL || state_q == S_VH) && !reset && !line_start;
  assign vram_addr         = {tile_row, (state_q == S_VH || state_q == S_VHW)};
  assign sprite_latch      = (state_q == S_EMIT) && !line_start;
  assign sprite_o_x        = out_x_q;
  assign sprite_o_priority = out_pri_q;
  assign sprite_o_data_h   = out_h_q;
  assign sprite_o_data_l   = out_l_q;
  assign busy              = (state_q != S_IDLE) && (state_q != S_FIN);
  assign done              = (state_q == S_FIN);
  assign sprite_count      = cnt_q;

endmodule

// File: tb/tb_sprite_fetcher.sv
module tb_sprite_fetcher;
  logic        clock = 1'b0, reset = 1'b1, line_start = 1'b0, sprite_tall = 1'b0;
  logic [7:0]  ly = 8'd0;
  logic [7:0]  oam_addr, oam_rdata = 8'd0;
  logic        vram_req, vram_gnt = 1'b0;
  logic [11:0] vram_addr;
  logic [7:0]  vram_rdata = 8'd0;
  logic        sprite_latch, sprite_o_priority, busy, done;
  logic [7:0]  sprite_o_x, sprite_o_data_h, sprite_o_data_l;
  logic [3:0]  sprite_count;

  sprite_fetcher dut (
    .clock(clock), .reset(reset), .line_start(line_start), .ly(ly), .sprite_tall(sprite_tall),
    .oam_addr(oam_addr), .oam_rdata(oam_rdata), .vram_req(vram_req), .vram_addr(vram_addr),
    .vram_gnt(vram_gnt), .vram_rdata(vram_rdata), .sprite_latch(sprite_latch),
    .sprite_o_x(sprite_o_x), .sprite_o_priority(sprite_o_priority),
    .sprite_o_data_h(sprite_o_data_h), .sprite_o_data_l(sprite_o_data_l),
    .busy(busy), .done(done), .sprite_count(sprite_count)
  );

  always #5 clock = ~clock;

  logic [7:0] oam  [0:255];
  logic [7:0] vmem [0:4095];
  always @(posedge clock) oam_rdata <= oam[oam_addr];
  always @(posedge clock) if (vram_req && vram_gnt) vram_rdata <= vmem[vram_addr];

  // 0: grant always, 1: random grant, 2: grant withheld
  int gnt_mode = 0;
  initial forever begin
    @(posedge clock); #2;
    case (gnt_mode)
      0:       vram_gnt = 1'b1;
      1:       vram_gnt = 1'($urandom_range(0, 1));
      default: vram_gnt = 1'b0;
    endcase
  end

  typedef struct packed {logic [7:0] x; logic pri; logic [7:0] h; logic [7:0] l;} spr_t;
  spr_t        exp_spr[$];
  logic [11:0] exp_addr[$];
  int          exp_count = 0;
  bit          expect_none = 0;

  int n_checks = 0, n_pass = 0;
  function void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endfunction

  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int k = 0; k < 8; k++) r[k] = v[7-k];
    return r;
  endfunction

  // Reference: list the sprites covering line l in OAM order, first 10 only.
  task automatic model_line(input logic [7:0] l, input logic t);
    int n, row, hgt, r, base;
    logic [7:0] tl, at, lo, hi;
    exp_spr.delete();
    exp_addr.delete();
    n = 0;
    for (int e = 0; e < 40 && n < 10; e++) begin
      row = (int'(l) + 16 - int'(oam[4*e]) + 256) % 256;
      hgt = t ? 16 : 8;
      if (row < hgt) begin
        tl = oam[4*e+2];
        at = oam[4*e+3];
        r  = row;
`ifdef SPRITE_FLIP_EN
        if (at[6]) r = hgt - 1 - row;
`endif
        base = t ? (int'(tl) / 2) * 32 + r * 2 : int'(tl) * 16 + r * 2;
        lo = vmem[base];
        hi = vmem[base+1];
`ifdef SPRITE_FLIP_EN
        if (at[5]) begin lo = rev8(lo); hi = rev8(hi); end
`endif
        exp_addr.push_back(12'(base));
        exp_addr.push_back(12'(base + 1));
        exp_spr.push_back('{x: oam[4*e+1], pri: at[7], h: hi, l: lo});
        n++;
      end
    end
    exp_count = n;
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents something.
  int cyc = 0, last_latch = -10;
  logic prev_req = 1'b0, prev_gnt = 1'b0;
  logic [11:0] prev_addr = '0;
  initial forever begin
    spr_t e;
    @(negedge clock);
    cyc++;
    if (!reset) begin
      if (prev_req && !prev_gnt && !line_start) begin
        chk("req_hold", 32'(vram_req), 32'd1);
        chk("addr_hold", 32'(vram_addr), 32'(prev_addr));
      end
      if (vram_req && vram_gnt) begin
        if (exp_addr.size() == 0) chk("extra_vram_fetch", 32'(vram_addr), 32'hFFFF_FFFF);
        else chk("vram_addr", 32'(vram_addr), 32'(exp_addr.pop_front()));
      end
      if (sprite_latch) begin
        if (expect_none || exp_spr.size() == 0) chk("extra_latch", 32'd1, 32'd0);
        else begin
          e = exp_spr.pop_front();
          chk("latch_x", 32'(sprite_o_x), 32'(e.x));
          chk("latch_pri", 32'(sprite_o_priority), 32'(e.pri));
          chk("latch_h", 32'(sprite_o_data_h), 32'(e.h));
          chk("latch_l", 32'(sprite_o_data_l), 32'(e.l));
        end
        last_latch = cyc;
      end
      if (done) begin
        chk("done_count", 32'(sprite_count), 32'(exp_count));
        chk("done_missing_latches", 32'(exp_spr.size()), 32'd0);
        if (exp_count == 10) chk("done_after_last_emit", 32'(cyc), 32'(last_latch + 1));
      end
    end
    prev_req  = vram_req;
    prev_gnt  = vram_gnt;
    prev_addr = vram_addr;
  end

  task automatic wait_done(output int c);
    @(negedge clock);
    c = 0;
    while (!done && c < 3000) begin @(negedge clock); c++; end
    if (!done) chk("done_timeout", 32'(c), 32'd0);
    @(negedge clock);
    chk("count_hold", 32'(sprite_count), 32'(exp_count));
  endtask

  task automatic run_line(input logic [7:0] l, input logic t, output int c);
    model_line(l, t);
    @(posedge clock); #1;
    ly = l; sprite_tall = t; line_start = 1'b1;
    @(posedge clock); #1;
    line_start = 1'b0;
    wait_done(c);
  endtask

  task automatic clear_oam();
    for (int k = 0; k < 256; k++) oam[k] = 8'd0;
  endtask

  task automatic set_entry(input int e, input logic [7:0] y, x, t, a);
    oam[4*e] = y; oam[4*e+1] = x; oam[4*e+2] = t; oam[4*e+3] = a;
  endtask

  initial begin
    int c;
    logic [11:0] a0;
    logic [7:0] rl;
    for (int k = 0; k < 4096; k++) vmem[k] = 8'($urandom);
    clear_oam();

    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_latch", 32'(sprite_latch), 32'd0);
    chk("rst_req", 32'(vram_req), 32'd0);
    chk("rst_oam_addr", 32'(oam_addr), 32'd0);
    chk("rst_vram_addr", 32'(vram_addr), 32'd0);
    chk("rst_count", 32'(sprite_count), 32'd0);
    chk("rst_x", 32'(sprite_o_x), 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;

    // Empty OAM: 2 cycles per miss over 40 entries.
    gnt_mode = 0;
    run_line(8'd0, 1'b0, c);
    chk("empty_done_latency", 32'(c), 32'd80);

    // Single sprite at entry 3.
    clear_oam();
    set_entry(3, 8'd16, 8'd40, 8'h12, 8'h80);
    run_line(8'd2, 1'b0, c);

    // Every entry hits: capped at 10.
    for (int e = 0; e < 40; e++) set_entry(e, 8'd20, 8'(e), 8'($urandom), 8'($urandom));
    gnt_mode = 1;
    run_line(8'd10, 1'b0, c);
    chk("full_line_count", 32'(sprite_count), 32'd10);

    // 8x16 addressing.
    clear_oam();
    set_entry(0, 8'd16, 8'd7, 8'h13, 8'h00);
    gnt_mode = 0;
    run_line(8'd12, 1'b1, c);

    // Flip attributes, row 1 (and row 6 for the flipped build).
    clear_oam();
    set_entry(5, 8'd16, 8'd0, 8'h22, 8'h60);
    vmem[12'h222] = 8'h01;
    vmem[12'h22C] = 8'h01;
    run_line(8'd1, 1'b0, c);

    // Withheld grant, then restart mid-fetch.
    clear_oam();
    set_entry(0, 8'd16, 8'd200, 8'h40, 8'h00);
    set_entry(9, 8'd17, 8'd168, 8'h41, 8'h80);
    gnt_mode = 2;
    expect_none = 1;
    exp_spr.delete(); exp_addr.delete();
    @(posedge clock); #1;
    ly = 8'd3; sprite_tall = 1'b0; line_start = 1'b1;
    @(posedge clock); #1;
    line_start = 1'b0;
    c = 0;
    while (!vram_req && c < 50) begin @(negedge clock); c++; end
    chk("stall_req_seen", 32'(vram_req), 32'd1);
    a0 = vram_addr;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      chk("stall_req", 32'(vram_req), 32'd1);
      chk("stall_addr", 32'(vram_addr), 32'(a0));
    end
    expect_none = 0;
    model_line(8'd3, 1'b0);
    @(posedge clock); #1;
    line_start = 1'b1;
    gnt_mode = 1;
    #1;
    chk("abort_req_drop", 32'(vram_req), 32'd0);
    @(posedge clock); #1;
    line_start = 1'b0;
    #1;
    chk("restart_entry0", 32'(oam_addr), 32'd0);
    chk("restart_busy", 32'(busy), 32'd1);
    wait_done(c);

    // Randomised lines.
    for (int n = 0; n < 6; n++) begin
      rl = 8'($urandom_range(0, 143));
      for (int e = 0; e < 40; e++)
        set_entry(e, 8'(int'(rl) + 16 - int'($urandom_range(0, 30))),
                  8'($urandom), 8'($urandom), 8'($urandom));
      gnt_mode = int'($urandom_range(0, 1));
      run_line(rl, 1'($urandom_range(0, 1)), c);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
